// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader
// Byte-serial loader for the 64-bit configuration register. It receives a
// framed byte stream (header, 8 payload bytes LSB first, XOR checksum byte),
// rebuilds the word, checks the checksum and the reserved top byte, and then
// either issues a one-cycle write strobe or flags a rejected frame.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active high
//   byte_valid   in   source presents a byte on byte_in
//   byte_in      in   stream byte
//   byte_ready   out  loader accepts a byte this cycle
//   cfg_wen      out  one-cycle write strobe to the config register
//   cfg_data_out out  last accepted config word
//   frame_err    out  one-cycle pulse on a rejected frame
//   err_cnt      out  saturating count of rejected frames
//   busy         out  frame in progress
module cfg_frame_loader #(
    parameter logic [7:0] HDR_BYTE      = 8'hA5,
    parameter int         PAYLOAD_BYTES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_in,
    output logic                       byte_ready,
    output logic                       cfg_wen,
    output logic [8*PAYLOAD_BYTES-1:0] cfg_data_out,
    output logic                       frame_err,
    output logic [7:0]                 err_cnt,
    output logic                       busy
);

    localparam int DW = 8 * PAYLOAD_BYTES;
    localparam int CW = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_WRITE,
        S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_shift;
    logic [7:0]      r_csum;
    logic [CW-1:0]   r_cnt;
    logic            w_accept;
    logic            w_frame_ok;

    assign byte_ready = !rst && (r_state == S_IDLE || r_state == S_PAYLOAD ||
                                 r_state == S_CHECK);
    assign w_accept   = byte_valid && byte_ready;
    // r_csum already holds the XOR of all payload bytes while in CHECK.
    assign w_frame_ok = (byte_in == r_csum) && (r_shift[DW-1:DW-8] == 8'h00);

    assign cfg_wen    = (r_state == S_WRITE);
    assign frame_err  = (r_state == S_ERROR);
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept && byte_in == HDR_BYTE) w_next = S_PAYLOAD;
            S_PAYLOAD: if (w_accept && r_cnt == LAST_IDX)   w_next = S_CHECK;
            S_CHECK:   if (w_accept) w_next = w_frame_ok ? S_WRITE : S_ERROR;
            S_WRITE:   w_next = S_IDLE;
            S_ERROR:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= '0;
            r_csum       <= 8'h00;
            r_cnt        <= '0;
            cfg_data_out <= '0;
            err_cnt      <= 8'h00;
        end else begin
            if (r_state == S_IDLE && w_accept && byte_in == HDR_BYTE) begin
                r_shift <= '0;
                r_csum  <= 8'h00;
                r_cnt   <= '0;
            end
            // Shift right so the first (least significant) byte ends at [7:0].
            if (r_state == S_PAYLOAD && w_accept) begin
                r_shift <= {byte_in, r_shift[DW-1:8]};
                r_csum  <= r_csum ^ byte_in;
                r_cnt   <= r_cnt + 1'b1;
            end
            // Load the word on the edge entering WRITE so it is visible
            // together with cfg_wen.
            if (r_state == S_CHECK && w_next == S_WRITE)
                cfg_data_out <= r_shift;
            if (r_state == S_CHECK && w_next == S_ERROR && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_cfg_frame_loader.sv
module tb_cfg_frame_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready;
    logic        cfg_wen;
    logic [63:0] cfg_data_out;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    always #5 clk = ~clk;

    cfg_frame_loader #(.HDR_BYTE(8'hA5), .PAYLOAD_BYTES(8)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_in(byte_in),
        .byte_ready(byte_ready), .cfg_wen(cfg_wen), .cfg_data_out(cfg_data_out),
        .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
    );

    typedef struct {
        logic        is_err;
        logic [63:0] data;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          nchk = 0;
    int          nerr = 0;
    int          wen_seen = 0;
    logic [63:0] exp_data = 64'h0;
    logic [7:0]  exp_err = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every strobe pops one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (cfg_wen || frame_err)) begin
            exp_t e;
            check("strobe_exclusive", 64'(cfg_wen && frame_err), 64'h0);
            check("ready_low_in_strobe", 64'(byte_ready), 64'h0);
            if (cfg_wen) wen_seen++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 64'(cfg_wen), 64'(frame_err));
                check("unexpected_event", 64'h1, 64'h0 + 64'(sb.size()));
            end else begin
                e = sb.pop_front();
                check("event_kind_err", 64'(frame_err), 64'(e.is_err));
                check("cfg_data_out", cfg_data_out, e.data);
                check("err_cnt", 64'(err_cnt), 64'(e.cnt));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", 64'h1, 64'h0);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    // ok is the hand-derived verdict for this frame.
    task automatic send_frame(input logic [63:0] w, input logic [7:0] ck,
                              input bit gap, input bit ok);
        exp_t e;
        send_byte(8'hA5, gap);
        for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8], gap);
        if (ok) exp_data = w;
        else if (exp_err != 8'hFF) exp_err = exp_err + 8'h01;
        e.is_err = !ok;
        e.data   = exp_data;
        e.cnt    = exp_err;
        sb.push_back(e);
        send_byte(ck, gap);
        @(negedge clk);
        check("latency_strobe", 64'(cfg_wen || frame_err), 64'h1);
    endtask

    initial begin
        #12;
        check("rst_ready", 64'(byte_ready), 64'h0);
        check("rst_data", cfg_data_out, 64'h0);
        check("rst_errcnt", 64'(err_cnt), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_wen", 64'(cfg_wen || frame_err), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(byte_ready), 64'h1);

        // Good frame, XOR of 01..07,00 is 00
        send_frame(64'h0007060504030201, 8'h00, 1'b0, 1'b1);
        // Bad checksum
        send_frame(64'h0007060504030201, 8'h01, 1'b0, 1'b0);
        // Reserved byte set, checksum correct (00 ^ 80)
        send_frame(64'h8007060504030201, 8'h80, 1'b0, 1'b0);

        // Garbage then gapped good frame
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hA4, 1'b0);
        @(negedge clk);
        check("garbage_idle", 64'(busy), 64'h0);
        check("garbage_errcnt", 64'(err_cnt), 64'h2);
        send_frame(64'h0007060504030201, 8'h00, 1'b1, 1'b1);

        // Reset after 4 payload bytes
        send_byte(8'hA5, 1'b0);
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data", cfg_data_out, 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_ready", 64'(byte_ready), 64'h0);
        check("mid_rst_errcnt", 64'(err_cnt), 64'h0);
        exp_data = 64'h0;
        exp_err  = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        // Header value inside payload; XOR 12^A5 = B7
        send_frame(64'h00A5000000000012, 8'hB7, 1'b0, 1'b1);

        // Saturation
        for (int i = 0; i < 260; i++)
            send_frame(64'h0007060504030201, 8'h01, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("sat_errcnt", 64'(err_cnt), 64'hFF);
        check("final_data", cfg_data_out, 64'h00A5000000000012);
        check("sb_drained", 64'(sb.size()), 64'h0);
        check("write_count", 64'(wen_seen), 64'h3);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
